frontend_sweep_controller: RTL
==============================

# frontend_sweep_controller

Sequencer for the ADC/DAC quadrature front end: steps the front end's phase increment through a programmed frequency sweep, waits for the increment feedback to converge and the mul-acc filters to settle, then captures the filtered SIN/COS mul-acc pair per point and hands it out over a valid/ready stream. Sits between the control/CPU side and the front end, driving its phase increment input and reading its filtered outputs. Used for sensor calibration and resonance search.

## Interface
- PHASE_INCREMENT_BITS, 28, width of phase increment values
- MUL_ACC_WIDTH, 32, width of captured SIN/COS mul-acc values
- SETTLE_BITS, 16, width of settle counter
- STEP_COUNT_BITS, 10, width of point count / index
- CLK  in  1  clock; one clock domain
- RESET  in  1  asynchronous, active-high reset
- CE  in  1  clock enable, same meaning as the front end (sample strobe)
- START  in  1  sweep start request; sampled when CE=1
- ABORT  in  1  abort sweep; evaluated every cycle, overrides all
- START_INC  in  PHASE_INCREMENT_BITS  first point increment
- STEP_INC  in  PHASE_INCREMENT_BITS  per-point increment delta (unsigned, wraps)
- STEP_COUNT  in  STEP_COUNT_BITS  number of points
- SETTLE_CYCLES  in  SETTLE_BITS  CE-cycles to wait after lock
- PHASE_INCREMENT_OUT  out  PHASE_INCREMENT_BITS  to front end phase increment input
- CURRENT_PHASE_INCREMENT  in  PHASE_INCREMENT_BITS  front end filtered feedback
- SIN_MUL_ACC, COS_MUL_ACC  in  MUL_ACC_WIDTH signed  front end filtered results
- RESULT_VALID  out  1  capture available
- RESULT_READY  in  1  consumer accepts
- RESULT_SIN, RESULT_COS  out  MUL_ACC_WIDTH signed  captured pair
- RESULT_INDEX  out  STEP_COUNT_BITS  point index, 0-based
- BUSY  out  1  sweep in progress
- DONE  out  1  one-cycle pulse after last point accepted

## Operation
- States: IDLE, LOCK, SETTLE, OUTPUT.
- IDLE: START=1 & CE=1 & STEP_COUNT!=0 -> latch START_INC/STEP_INC/STEP_COUNT/SETTLE_CYCLES, PHASE_INCREMENT_OUT<=START_INC, index<=0, -> LOCK. START with STEP_COUNT=0 ignored. START outside IDLE ignored.
- LOCK (CE=1): CURRENT_PHASE_INCREMENT == PHASE_INCREMENT_OUT -> load counter with latched SETTLE_CYCLES, -> SETTLE.
- SETTLE (CE=1): counter==0 -> capture SIN/COS into RESULT_*, RESULT_VALID<=1, -> OUTPUT; else counter-1. SETTLE_CYCLES=0 captures on the first CE cycle in SETTLE.
- OUTPUT (not CE-gated): RESULT_VALID & RESULT_READY -> RESULT_VALID<=0; if index==count-1 -> DONE pulse, -> IDLE; else index+1, PHASE_INCREMENT_OUT += STEP_INC (mod 2^PHASE_INCREMENT_BITS), -> LOCK.
- RESULT_* stable while RESULT_VALID=1; PHASE_INCREMENT_OUT holds during OUTPUT.
- ABORT=1: -> IDLE next edge, RESULT_VALID<=0, no DONE, PHASE_INCREMENT_OUT holds last value. ABORT with START same cycle: ABORT wins.
- PHASE_INCREMENT_OUT holds last value in IDLE (front end keeps running).

## Timing
- Reset values: PHASE_INCREMENT_OUT=0, RESULT_*=0, RESULT_VALID=0, BUSY=0, DONE=0, state IDLE.
- BUSY=1 from cycle after accepted START until cycle DONE asserts (BUSY=0 same cycle as DONE) or abort.
- START accept -> PHASE_INCREMENT_OUT updated 1 cycle later.
- Lock detect -> capture: SETTLE_CYCLES+1 CE cycles.
- Accept handshake -> next point increment on PHASE_INCREMENT_OUT next cycle; RESULT_VALID low at least one cycle between points.
- All outputs registered.

## Configuration
- FRONTEND_SWEEP_PEAK_TRACK_EN defined: adds outputs PEAK_INDEX (STEP_COUNT_BITS) and PEAK_MAG (MUL_ACC_WIDTH+1, unsigned |sin|+|cos|); updated at each capture when magnitude strictly greater than stored; cleared to 0 on accepted START and reset; ties keep lower index.
- Undefined: ports absent, no magnitude logic.

## Test plan
- Reset mid-sweep (state SETTLE) -> all outputs 0 immediately, BUSY=0, no DONE.
- START_INC=0x100000, STEP_INC=0x1000, STEP_COUNT=4, SETTLE=8, feedback tracks output with delay 5, READY=1 -> 4 results, indices 0..3, increments 0x100000..0x103000, DONE one pulse, BUSY drops same cycle.
- READY held low 20 cycles at point 1 -> RESULT_* stable, PHASE_INCREMENT_OUT stays 0x101000, resumes on READY.
- START_INC=0xFFFF000, STEP_INC=0x2000, STEP_COUNT=2 -> second increment 0x0001000 (wrap).
- ABORT during OUTPUT with START same cycle -> IDLE, VALID=0, no DONE; subsequent START with STEP_COUNT=0 ignored.
- FRONTEND_SWEEP_PEAK_TRACK_EN: captures (sin,cos)=(100,-50),(-200,10),(150,60) -> PEAK_INDEX=1, PEAK_MAG=210.

Source files
------------

// File: rtl/frontend_sweep_controller.sv
// frontend_sweep_controller
// Steps the front-end phase increment through a programmed frequency sweep.
// For each point it waits for the increment feedback to match, waits a
// programmed number of CE cycles for the mul-acc filters to settle, then
// captures the SIN/COS pair and offers it on a valid/ready stream.
// Optional feature: define FRONTEND_SWEEP_PEAK_TRACK_EN to add PEAK_INDEX /
// PEAK_MAG, which track the point with the largest |sin|+|cos|.
module frontend_sweep_controller #(
   parameter int PHASE_INCREMENT_BITS = 28,
   parameter int MUL_ACC_WIDTH        = 32,
   parameter int SETTLE_BITS          = 16,
   parameter int STEP_COUNT_BITS      = 10
) (
   input  logic                                   CLK,
   input  logic                                   RESET,
   input  logic                                   CE,
   input  logic                                   START,
   input  logic                                   ABORT,
   input  logic        [PHASE_INCREMENT_BITS-1:0] START_INC,
   input  logic        [PHASE_INCREMENT_BITS-1:0] STEP_INC,
   input  logic        [STEP_COUNT_BITS-1:0]      STEP_COUNT,
   input  logic        [SETTLE_BITS-1:0]          SETTLE_CYCLES,
   output logic        [PHASE_INCREMENT_BITS-1:0] PHASE_INCREMENT_OUT,
   input  logic        [PHASE_INCREMENT_BITS-1:0] CURRENT_PHASE_INCREMENT,
   input  logic signed [MUL_ACC_WIDTH-1:0]        SIN_MUL_ACC,
   input  logic signed [MUL_ACC_WIDTH-1:0]        COS_MUL_ACC,
   output logic                                   RESULT_VALID,
   input  logic                                   RESULT_READY,
   output logic signed [MUL_ACC_WIDTH-1:0]        RESULT_SIN,
   output logic signed [MUL_ACC_WIDTH-1:0]        RESULT_COS,
   output logic        [STEP_COUNT_BITS-1:0]      RESULT_INDEX,
   output logic                                   BUSY,
   output logic                                   DONE
`ifdef FRONTEND_SWEEP_PEAK_TRACK_EN
   ,
   output logic        [STEP_COUNT_BITS-1:0]      PEAK_INDEX,
   output logic        [MUL_ACC_WIDTH:0]          PEAK_MAG
`endif
);

   localparam logic [STEP_COUNT_BITS-1:0] IDX_ONE    = 1;
   localparam logic [SETTLE_BITS-1:0]     SETTLE_ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_LOCK, S_SETTLE, S_OUTPUT} state_t;

   state_t                            state_q;
   logic [PHASE_INCREMENT_BITS-1:0]   inc_q;
   logic [PHASE_INCREMENT_BITS-1:0]   step_q;
   logic [STEP_COUNT_BITS-1:0]        count_q;
   logic [STEP_COUNT_BITS-1:0]        index_q;
   logic [SETTLE_BITS-1:0]            settle_q;
   logic [SETTLE_BITS-1:0]            cnt_q;
   logic                              valid_q;
   logic                              busy_q;
   logic                              done_q;
   logic signed [MUL_ACC_WIDTH-1:0]   sin_q;
   logic signed [MUL_ACC_WIDTH-1:0]   cos_q;

   logic start_acc_d;
   logic capture_d;
   logic last_pt_d;

   // ABORT overrides everything, so neither a start nor a capture may fire alongside it
   assign start_acc_d = !ABORT && (state_q == S_IDLE) && CE && START && (STEP_COUNT != '0);
   assign capture_d   = !ABORT && (state_q == S_SETTLE) && CE && (cnt_q == '0);
   assign last_pt_d   = (index_q == (count_q - IDX_ONE));

   // Sweep sequencer: IDLE -> LOCK -> SETTLE -> OUTPUT, looping per point
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         inc_q    <= '0;
         step_q   <= '0;
         count_q  <= '0;
         index_q  <= '0;
         settle_q <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sin_q    <= '0;
         cos_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (ABORT) begin
            // Increment output deliberately holds so the front end keeps running
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start_acc_d) begin
                     inc_q    <= START_INC;
                     step_q   <= STEP_INC;
                     count_q  <= STEP_COUNT;
                     settle_q <= SETTLE_CYCLES;
                     index_q  <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= S_LOCK;
                  end
               end
               S_LOCK: begin
                  if (CE && (CURRENT_PHASE_INCREMENT == inc_q)) begin
                     cnt_q   <= settle_q;
                     state_q <= S_SETTLE;
                  end
               end
               S_SETTLE: begin
                  if (CE) begin
                     if (cnt_q == '0) begin
                        sin_q   <= SIN_MUL_ACC;
                        cos_q   <= COS_MUL_ACC;
                        valid_q <= 1'b1;
                        state_q <= S_OUTPUT;
                     end else begin
                        cnt_q <= cnt_q - SETTLE_ONE;
                     end
                  end
               end
               S_OUTPUT: begin
                  if (valid_q && RESULT_READY) begin
                     valid_q <= 1'b0;
                     if (last_pt_d) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                     end else begin
                        index_q <= index_q + IDX_ONE;
                        inc_q   <= inc_q + step_q;
                        state_q <= S_LOCK;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign PHASE_INCREMENT_OUT = inc_q;
   assign RESULT_VALID        = valid_q;
   assign RESULT_SIN          = sin_q;
   assign RESULT_COS          = cos_q;
   assign RESULT_INDEX        = index_q;
   assign BUSY                = busy_q;
   assign DONE                = done_q;

`ifdef FRONTEND_SWEEP_PEAK_TRACK_EN
   // |a|+|b| one bit wider than the inputs; |most-negative| still fits unsigned
   function automatic logic [MUL_ACC_WIDTH:0] abs_sum(input logic signed [MUL_ACC_WIDTH-1:0] a,
                                                      input logic signed [MUL_ACC_WIDTH-1:0] b);
      logic [MUL_ACC_WIDTH:0] ua;
      logic [MUL_ACC_WIDTH:0] ub;
      ua = a[MUL_ACC_WIDTH-1] ? {1'b0, -a} : {1'b0, a};
      ub = b[MUL_ACC_WIDTH-1] ? {1'b0, -b} : {1'b0, b};
      return ua + ub;
   endfunction

   logic [MUL_ACC_WIDTH:0]   mag_d;
   logic [MUL_ACC_WIDTH:0]   peak_mag_q;
   logic [STEP_COUNT_BITS-1:0] peak_idx_q;

   assign mag_d = abs_sum(SIN_MUL_ACC, COS_MUL_ACC);

   // Peak tracker: strictly-greater update keeps the lower index on ties
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         peak_mag_q <= '0;
         peak_idx_q <= '0;
      end else if (start_acc_d) begin
         peak_mag_q <= '0;
         peak_idx_q <= '0;
      end else if (capture_d && (mag_d > peak_mag_q)) begin
         peak_mag_q <= mag_d;
         peak_idx_q <= index_q;
      end
   end

   assign PEAK_INDEX = peak_idx_q;
   assign PEAK_MAG   = peak_mag_q;
`endif

endmodule
